// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard/forwarding controller with multi-cycle mul/div busy tracking.
// Optional counters enabled by `define HAZ_PERF_CNT_EN (stall_cnt, md_stall_cnt).
module pipe_hazard_ctrl #(
  parameter int unsigned NREG_BITS  = 5,
  parameter int unsigned FWD_STAGES = 3,
  parameter int unsigned MD_LAT     = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 id_valid,
  input  logic [NREG_BITS-1:0]                 id_rs,
  input  logic [NREG_BITS-1:0]                 id_rt,
  input  logic                                 id_use_rs,
  input  logic                                 id_use_rt,
  input  logic                                 id_md_start,
  input  logic                                 id_md_read,
  input  logic [FWD_STAGES-1:0]                stg_wreg,
  input  logic [FWD_STAGES*NREG_BITS-1:0]      stg_rn,
  input  logic [FWD_STAGES-1:0]                stg_ready,
  output logic [$clog2(FWD_STAGES+1)-1:0]      fwda,
  output logic [$clog2(FWD_STAGES+1)-1:0]      fwdb,
  output logic                                 nostall,
  output logic                                 md_busy,
  output logic                                 md_done,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0]                     md_stall_cnt,
`endif
  output logic [CNT_W-1:0]                     stall_cnt
);

  localparam int unsigned FW = $clog2(FWD_STAGES + 1);
  localparam logic [7:0]  MD_LAT_C = 8'(MD_LAT);

  logic       hit_a, hit_b, haz_a, haz_b, md_haz, md_start;
  logic [7:0] md_cnt_q, md_cnt_d;
  logic       md_done_q;

  // Youngest matching stage wins; the first hit latches code and readiness.
  always_comb begin
    logic [NREG_BITS-1:0] slice;
    slice = '0;
    fwda  = '0;
    fwdb  = '0;
    hit_a = 1'b0;
    hit_b = 1'b0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int unsigned k = 0; k < FWD_STAGES; k++) begin
      slice = stg_rn[k*NREG_BITS +: NREG_BITS];
      if (stg_wreg[k] && (slice != '0)) begin
        if (!hit_a && id_valid && id_use_rs && (slice == id_rs)) begin
          hit_a = 1'b1;
          fwda  = FW'(k + 1);
          haz_a = ~stg_ready[k];
        end
        if (!hit_b && id_valid && id_use_rt && (slice == id_rt)) begin
          hit_b = 1'b1;
          fwdb  = FW'(k + 1);
          haz_b = ~stg_ready[k];
        end
      end
    end
  end

  assign md_busy  = (md_cnt_q != '0);
  assign md_haz   = id_valid & (id_md_read | id_md_start) & md_busy;
  assign nostall  = ~(haz_a | haz_b | md_haz);
  assign md_start = id_valid & id_md_start & nostall;
  assign md_done  = md_done_q;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start)
      md_cnt_d = MD_LAT_C;
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_cnt_q  <= '0;
      md_done_q <= 1'b0;
    end else begin
      md_cnt_q  <= md_cnt_d;
      md_done_q <= (md_cnt_q == 8'd1) && !md_start;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, md_stall_q, md_stall_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    md_stall_d  = md_stall_q;
    if (!nostall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (md_haz && (md_stall_q != '1))
      md_stall_d = md_stall_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      md_stall_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      md_stall_q  <= md_stall_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed plan steps plus randomized traffic.
module tb_pipe_hazard_ctrl;

  localparam int NB   = 5;
  localparam int FS   = 3;
  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clock, reset;
  logic             id_valid, id_use_rs, id_use_rt, id_md_start, id_md_read;
  logic [NB-1:0]    id_rs, id_rt;
  logic [FS-1:0]    stg_wreg, stg_ready;
  logic [FS*NB-1:0] stg_rn;
  logic [1:0]       fwda, fwdb;
  logic             nostall, md_busy, md_done;
  logic [CW-1:0]    stall_cnt;
`ifdef HAZ_PERF_CNT_EN
  logic [CW-1:0]    md_stall_cnt;
`endif

  pipe_hazard_ctrl #(.NREG_BITS(NB), .FWD_STAGES(FS), .MD_LAT(LAT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md_start(id_md_start), .id_md_read(id_md_read),
    .stg_wreg(stg_wreg), .stg_rn(stg_rn), .stg_ready(stg_ready),
    .fwda(fwda), .fwdb(fwdb), .nostall(nostall),
    .md_busy(md_busy), .md_done(md_done),
`ifdef HAZ_PERF_CNT_EN
    .md_stall_cnt(md_stall_cnt),
`endif
    .stall_cnt(stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int npass = 0, nchk = 0;
  // Reference state: cycle index, cycle of last accepted start, counters.
  int cyc = 0, last_start = -1000, stall_exp = 0, mdst_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic void model_fwd(input logic [NB-1:0] r, input logic used,
                                    output int code, output bit haz);
    code = 0;
    haz  = 1'b0;
    if (id_valid && used && r != 0)
      for (int k = FS; k >= 1; k--)
        if (stg_wreg[k-1] && stg_rn[(k-1)*NB +: NB] == r) begin
          code = k;
          haz  = !stg_ready[k-1];
        end
  endfunction

  task automatic set_stg(input int k, input logic w, input logic [NB-1:0] rn, input logic rdy);
    stg_wreg[k-1]            = w;
    stg_rn[(k-1)*NB +: NB]   = rn;
    stg_ready[k-1]           = rdy;
  endtask

  task automatic set_id(input logic v, input logic [NB-1:0] rs, input logic urs,
                        input logic [NB-1:0] rt, input logic urt,
                        input logic st, input logic rd);
    id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_md_start = st; id_md_read = rd;
  endtask

  task automatic step(input string tag);
    int ca, cb;
    bit ha, hb, busy, done, mh, ns;
    model_fwd(id_rs, id_use_rs, ca, ha);
    model_fwd(id_rt, id_use_rt, cb, hb);
    busy = (cyc > last_start) && (cyc <= last_start + LAT);
    done = (cyc == last_start + LAT + 1);
    mh   = id_valid && (id_md_read || id_md_start) && busy;
    ns   = !(ha || hb || mh);
    #3;
    chk({tag, ".fwda"},    32'(fwda),      32'(ca));
    chk({tag, ".fwdb"},    32'(fwdb),      32'(cb));
    chk({tag, ".nostall"}, 32'(nostall),   32'(ns));
    chk({tag, ".md_busy"}, 32'(md_busy),   32'(busy));
    chk({tag, ".md_done"}, 32'(md_done),   32'(done));
    chk({tag, ".stall"},   32'(stall_cnt), 32'(stall_exp));
`ifdef HAZ_PERF_CNT_EN
    chk({tag, ".mdstall"}, 32'(md_stall_cnt), 32'(mdst_exp));
`endif
    @(posedge clock);
    if (PERF && !ns && stall_exp < SMAX) stall_exp++;
    if (PERF && mh && mdst_exp < SMAX) mdst_exp++;
    if (id_valid && id_md_start && ns) last_start = cyc;
    cyc++;
    #1;
  endtask

  task automatic mid_reset(input string tag);
    set_id(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk({tag, ".busy"},  32'(md_busy),   32'd0);
    chk({tag, ".done"},  32'(md_done),   32'd0);
    chk({tag, ".stall"}, 32'(stall_cnt), 32'd0);
    last_start = -1000;
    stall_exp  = 0;
    mdst_exp   = 0;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stg_wreg = '0; stg_rn = '0; stg_ready = '0;
    set_id(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst.busy",  32'(md_busy),   32'd0);
    chk("rst.done",  32'(md_done),   32'd0);
    chk("rst.stall", 32'(stall_cnt), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Plan 1: two matching ready stages, youngest wins.
    set_stg(1, 1, 5'd8, 1); set_stg(2, 1, 5'd8, 1); set_stg(3, 0, 5'd0, 1);
    set_id(1, 5'd8, 1, 5'd3, 1, 0, 0);
    step("p1");
    chk("p1.fwda_is_1", 32'(fwda), 32'd1);

    // Plan 2: youngest not ready stalls even though stage 2 is ready.
    set_stg(1, 1, 5'd8, 0);
    for (int i = 0; i < 3; i++) step("p2");
    set_stg(1, 1, 5'd8, 1);
    step("p2r");

    // Plan 3: r0 never matches.
    for (int k = 1; k <= FS; k++) set_stg(k, 1, 5'd0, 0);
    set_id(1, 5'd0, 1, 5'd0, 1, 0, 0);
    step("p3");

    // Plan 4: start, then HI/LO read stalls until the result is readable.
    for (int k = 1; k <= FS; k++) set_stg(k, 0, 5'd0, 1);
    set_id(1, 5'd1, 1, 5'd2, 1, 1, 0);
    step("p4s");
    set_id(0, '0, 0, '0, 0, 0, 0);
    step("p4b");
    set_id(1, 5'd1, 1, 5'd2, 1, 0, 1);
    for (int i = 0; i < 4; i++) step("p4r");
    set_id(0, '0, 0, '0, 0, 0, 0);
    step("p4e");

    // Plan 5: back-to-back start held until the counter drains.
    set_id(1, 5'd1, 0, 5'd2, 0, 1, 0);
    for (int i = 0; i < 6; i++) step("p5");
    set_id(0, '0, 0, '0, 0, 0, 0);
    step("p5b");
    mid_reset("p5rst");
    for (int i = 0; i < 6; i++) step("p5post");

    // Plan 6: 2^CNT_W+3 stall cycles saturate the counter.
    mid_reset("p6rst");
    set_stg(1, 1, 5'd8, 0);
    set_id(1, 5'd8, 1, 5'd0, 0, 0, 0);
    for (int i = 0; i < (1 << CW) + 3; i++) step("p6");
    #3;
    chk("p6.sat", 32'(stall_cnt), PERF ? 32'(SMAX) : 32'd0);
    @(posedge clock); #1; cyc++;
    if (PERF && stall_exp < SMAX) stall_exp++;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 1; k <= FS; k++)
        set_stg(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      set_id(1'($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0));
      step("rnd");
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
